// File: rtl/asg_sweep_loader.sv
// -----------------------------------------------------------------------------
// asg_sweep_loader
//
// Loads one radar sweep bitmap (SIZE range bins, one bit per microsecond) from
// a 32-bit AXI-Stream-style word stream into a shadow buffer. Once a complete,
// correctly framed sweep is held, the next radar trigger copies it to DATA and
// enables the azimuth signal generator. A trigger that arrives while no
// complete sweep is available is counted as an underrun and disables the
// generator, leaving DATA unchanged.
//
// Ports
//   SYS_CLK        in   1      sole clock
//   SYS_RESETN     in   1      asynchronous active-low reset
//   ARM            in   1      level, 1 = loader active, 0 = loader idle
//   RADAR_TRIG_PE  in   1      single-cycle trigger pulse
//   S_TDATA        in   32     sweep word, bit i of word k = range bin 32k+i
//   S_TVALID       in   1      word valid
//   S_TLAST        in   1      final word of a sweep
//   S_TREADY       out  1      loader can accept a word
//   DATA           out  SIZE   active sweep bitmap
//   EN             out  1      generator enable
//   UNDERRUN_CNT   out  CNT_W  saturating count of underrun triggers
//   FRAME_ERR      out  1      one-cycle pulse per framing error
//   CLR_CNT        in   1      synchronous clear of UNDERRUN_CNT
// -----------------------------------------------------------------------------
module asg_sweep_loader #(
  parameter int SIZE  = 3200,
  parameter int CNT_W = 16
) (
  input  logic             SYS_CLK,
  input  logic             SYS_RESETN,
  input  logic             ARM,
  input  logic             RADAR_TRIG_PE,
  input  logic [31:0]      S_TDATA,
  input  logic             S_TVALID,
  input  logic             S_TLAST,
  output logic             S_TREADY,
  output logic [SIZE-1:0]  DATA,
  output logic             EN,
  output logic [CNT_W-1:0] UNDERRUN_CNT,
  output logic             FRAME_ERR,
  input  logic             CLR_CNT
);

  localparam int NW        = (SIZE + 31) / 32;
  localparam int KW        = (NW > 1) ? $clog2(NW) : 1;
  // Number of meaningful bits in the final word of a sweep.
  localparam int LAST_BITS = SIZE - 32 * (NW - 1);
  localparam logic [KW-1:0] K_LAST = KW'(NW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [KW-1:0]   k;
  logic [KW-1:0]   k_nx;
  logic [SIZE-1:0] shadow;

  logic             accept;
  logic             at_last;
  logic             shadow_we;
  logic             trig_load;
  logic             trig_underrun;
  logic             ready_nx;
  logic             en_nx;
  logic             frame_err_nx;
  logic [CNT_W-1:0] cnt_nx;

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ARM gates acceptance so that a word offered in the cycle ARM drops is
  // not consumed, even though S_TREADY (registered) may still read 1.
  assign accept  = S_TVALID & S_TREADY & ARM;
  assign at_last = (k == K_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
    if (!SYS_RESETN) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    k_nx     = k;
    if (!ARM) begin
      state_nx = IDLE;
      k_nx     = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = FILL;
          k_nx     = '0;
        end
        FILL: begin
          if (accept) begin
            if (at_last) begin
              // Final word: a proper TLAST completes the sweep; a missing
              // TLAST means the producer is misaligned, so swallow the rest
              // of its frame before filling again.
              state_nx = S_TLAST ? READY : DRAIN;
              k_nx     = '0;
            end else if (S_TLAST) begin
              // Early TLAST: restart the fill from word 0.
              k_nx = '0;
            end else begin
              k_nx = k + KW'(1);
            end
          end
        end
        READY: begin
          if (RADAR_TRIG_PE) begin
            state_nx = FILL;
            k_nx     = '0;
          end
        end
        DRAIN: begin
          if (accept && S_TLAST) begin
            state_nx = FILL;
            k_nx     = '0;
          end
        end
        default: begin
          state_nx = IDLE;
          k_nx     = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    shadow_we     = (state == FILL) && accept;
    frame_err_nx  = (state == FILL) && accept && (at_last != S_TLAST);
    trig_load     = ARM && (state == READY) && RADAR_TRIG_PE;
    // An underrun is any trigger seen while a sweep is still being assembled
    // or drained, including one coincident with the completing word.
    trig_underrun = RADAR_TRIG_PE && ((state == FILL) || (state == DRAIN));
    ready_nx      = (state_nx == FILL) || (state_nx == DRAIN);

    en_nx = EN;
    if (!ARM) begin
      en_nx = 1'b0;
    end else if (trig_load) begin
      en_nx = 1'b1;
    end else if (trig_underrun) begin
      en_nx = 1'b0;
    end

    // Clear wins over a coincident underrun.
    if (CLR_CNT) begin
      cnt_nx = '0;
    end else if (trig_underrun) begin
      cnt_nx = sat_inc(UNDERRUN_CNT);
    end else begin
      cnt_nx = UNDERRUN_CNT;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
    if (!SYS_RESETN) begin
      S_TREADY     <= 1'b0;
      EN           <= 1'b0;
      FRAME_ERR    <= 1'b0;
      UNDERRUN_CNT <= '0;
    end else begin
      S_TREADY     <= ready_nx;
      EN           <= en_nx;
      FRAME_ERR    <= frame_err_nx;
      UNDERRUN_CNT <= cnt_nx;
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
    if (!SYS_RESETN) begin
      DATA <= '0;
    end else if (trig_load) begin
      DATA <= shadow;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow buffer: one write-enabled word slice per index. The final slice is
  // only LAST_BITS wide, so stream bits beyond SIZE are simply dropped.
  // ---------------------------------------------------------------------------
  for (genvar w = 0; w < NW; w++) begin : g_word
    localparam int WB = (w == NW - 1) ? LAST_BITS : 32;
    always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
      if (!SYS_RESETN) begin
        shadow[w*32 +: WB] <= '0;
      end else if (shadow_we && (k == KW'(w))) begin
        shadow[w*32 +: WB] <= S_TDATA[WB-1:0];
      end
    end
  end

endmodule
